flash_rom_loader: RTL and testbench

// Boot-time copier between parallel flash and SRAM. After reset or a start pulse it reads LEN bytes from flash at SRC_BASE.
// It packs byte pairs into 16-bit words and writes them through the SRAM arbiter's write port, starting at word address DST_BASE.

---
 rtl/flash_rom_loader.sv | 192 +++++++++++++++++++
 tb/tb_flash_rom_loader.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/flash_rom_loader.sv
`timescale 1ns/1ps
// Boot copier: streams LEN flash bytes into SRAM as 16-bit words and keeps the Z80 in reset until done.
// Latency: 2+FLASH_WAIT cycles per byte, plus 1 request cycle and the arbiter ack delay per word.
// Backpressure: holds w_req with stable addr/data/be until w_ack; flash access is paused meanwhile.
module flash_rom_loader #(
    parameter logic [21:0] SRC_BASE   = 22'h000000,
    parameter logic [17:0] DST_BASE   = 18'h00000,
    parameter int unsigned LEN        = 16384,
    parameter int unsigned FLASH_WAIT = 3,
    parameter bit          AUTOSTART  = 1'b1
) (
    input  logic        zclk,
    input  logic        rst,
    input  logic        start,
    output logic [21:0] flash_a,
    output logic        flash_ce_n,
    output logic        flash_oe_n,
    input  logic [7:0]  flash_d,
    output logic        w_req,
    output logic [17:0] w_addr,
    output logic [15:0] w_data,
    output logic [1:0]  w_be,
    input  logic        w_ack,
    output logic        cpu_hold,
    output logic        busy,
    output logic        done,
    output logic [15:0] checksum
);

    typedef enum logic [2:0] {
        S_IDLE, S_FADDR, S_FWAIT, S_FLATCH, S_WREQ, S_DONE
    } state_t;

    localparam logic [16:0] LEN_C     = 17'(LEN);
    localparam bit          HAS_WAIT  = (FLASH_WAIT != 0);
    localparam logic [15:0] WAIT_LAST = (FLASH_WAIT > 0) ? 16'(FLASH_WAIT - 1) : 16'd0;

    state_t      state_q, state_d;
    logic [15:0] i_q, i_d;
    logic [15:0] wait_q, wait_d;
    logic [21:0] flash_a_q, flash_a_d;
    logic        flash_en_n_q, flash_en_n_d;  // CE and OE always move together
    logic        w_req_q, w_req_d;
    logic [17:0] w_addr_q, w_addr_d;
    logic [15:0] w_data_q, w_data_d;
    logic [1:0]  w_be_q, w_be_d;
    logic        cpu_hold_q, cpu_hold_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [15:0] checksum_q, checksum_d;

    logic [15:0] i_inc;
    logic        more;
    logic        go;

    assign i_inc = i_q + 16'd1;
    assign more  = (({1'b0, i_q} + 17'd1) < LEN_C);

    // Next-state and registered-output computation for the copy sequencer
    always_comb begin
        state_d      = state_q;
        i_d          = i_q;
        wait_d       = wait_q;
        flash_a_d    = flash_a_q;
        flash_en_n_d = flash_en_n_q;
        w_req_d      = w_req_q;
        w_addr_d     = w_addr_q;
        w_data_d     = w_data_q;
        w_be_d       = w_be_q;
        cpu_hold_d   = cpu_hold_q;
        busy_d       = busy_q;
        done_d       = done_q;
        checksum_d   = checksum_q;
        go           = 1'b0;

        case (state_q)
            S_IDLE: go = AUTOSTART || start;
            S_DONE: go = start;
            S_FADDR: begin
                if (HAS_WAIT) begin
                    state_d = S_FWAIT;
                    wait_d  = 16'd0;
                end else begin
                    state_d = S_FLATCH;
                end
            end
            S_FWAIT: begin
                if (wait_q == WAIT_LAST) state_d = S_FLATCH;
                else                     wait_d  = wait_q + 16'd1;
            end
            S_FLATCH: begin
                checksum_d = checksum_q + {8'h00, flash_d};
                // Even byte clears the upper lane so an odd-length tail writes zero there
                if (i_q[0]) w_data_d[15:8] = flash_d;
                else        w_data_d       = {8'h00, flash_d};
                if (!i_q[0] && more) begin
                    i_d       = i_inc;
                    flash_a_d = SRC_BASE + {6'b0, i_inc};
                    state_d   = S_FADDR;
                end else begin
                    state_d      = S_WREQ;
                    flash_en_n_d = 1'b1;
                    w_req_d      = 1'b1;
                    w_addr_d     = DST_BASE + {3'b0, i_q[15:1]};
                    w_be_d       = i_q[0] ? 2'b11 : 2'b01;
                end
            end
            S_WREQ: begin
                if (w_ack) begin
                    w_req_d = 1'b0;
                    if (more) begin
                        i_d          = i_inc;
                        flash_a_d    = SRC_BASE + {6'b0, i_inc};
                        flash_en_n_d = 1'b0;
                        state_d      = S_FADDR;
                    end else begin
                        state_d    = S_DONE;
                        busy_d     = 1'b0;
                        done_d     = 1'b1;
                        cpu_hold_d = 1'b0;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Launch (or relaunch) a copy; an empty image finishes immediately
        if (go) begin
            checksum_d = 16'h0000;
            if (LEN_C == 17'd0) begin
                state_d    = S_DONE;
                busy_d     = 1'b0;
                done_d     = 1'b1;
                cpu_hold_d = 1'b0;
            end else begin
                state_d      = S_FADDR;
                i_d          = 16'd0;
                flash_a_d    = SRC_BASE;
                flash_en_n_d = 1'b0;
                busy_d       = 1'b1;
                done_d       = 1'b0;
                cpu_hold_d   = 1'b1;
            end
        end
    end

    // State and output registers with synchronous reset
    always_ff @(posedge zclk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            i_q          <= 16'd0;
            wait_q       <= 16'd0;
            flash_a_q    <= 22'd0;
            flash_en_n_q <= 1'b1;
            w_req_q      <= 1'b0;
            w_addr_q     <= 18'd0;
            w_data_q     <= 16'd0;
            w_be_q       <= 2'b00;
            cpu_hold_q   <= 1'b1;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            checksum_q   <= 16'd0;
        end else begin
            state_q      <= state_d;
            i_q          <= i_d;
            wait_q       <= wait_d;
            flash_a_q    <= flash_a_d;
            flash_en_n_q <= flash_en_n_d;
            w_req_q      <= w_req_d;
            w_addr_q     <= w_addr_d;
            w_data_q     <= w_data_d;
            w_be_q       <= w_be_d;
            cpu_hold_q   <= cpu_hold_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            checksum_q   <= checksum_d;
        end
    end

    assign flash_a    = flash_a_q;
    assign flash_ce_n = flash_en_n_q;
    assign flash_oe_n = flash_en_n_q;
    assign w_req      = w_req_q;
    assign w_addr     = w_addr_q;
    assign w_data     = w_data_q;
    assign w_be       = w_be_q;
    assign cpu_hold   = cpu_hold_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign checksum   = checksum_q;

endmodule

// File: tb/tb_flash_rom_loader.sv
`timescale 1ns/1ps
// Bench for flash_rom_loader: three instances (LEN=4 autostart, LEN=3 wrapping addresses, LEN=0).
// Flash model only returns real data after the access time; arbiter model has a programmable ack delay.
// Expected writes are queued by the stimulus and popped by a negedge monitor.
module tb_flash_rom_loader;

    localparam logic [21:0] SRC_A = 22'h000100;
    localparam logic [17:0] DST_A = 18'h00040;
    localparam int          FW_A  = 3;
    localparam logic [21:0] SRC_B = 22'h3FFFFE;
    localparam logic [17:0] DST_B = 18'h3FFFF;
    localparam int          FW_B  = 0;

    logic zclk = 1'b0;
    logic rst = 1'b1;
    logic start_a = 1'b0, start_b = 1'b0, start_c = 1'b0;

    logic [21:0] fa_a, fa_b, fa_c;
    logic        ce_a, ce_b, ce_c, oe_a, oe_b, oe_c;
    logic [7:0]  fd_a, fd_b;
    logic [7:0]  fd_c = 8'h00;
    logic        wreq_a, wreq_b, wreq_c;
    logic [17:0] waddr_a, waddr_b, waddr_c;
    logic [15:0] wdata_a, wdata_b, wdata_c;
    logic [1:0]  wbe_a, wbe_b, wbe_c;
    logic        wack_a = 1'b0, wack_b = 1'b0;
    logic        wack_c = 1'b0;
    logic        hold_a, hold_b, hold_c, busy_a, busy_b, busy_c, done_a, done_b, done_c;
    logic [15:0] cks_a, cks_b, cks_c;

    int n_cmp = 0;
    int n_err = 0;

    logic [35:0] qa[$];
    logic [35:0] qb[$];

    int          cnt_a = 0, cnt_b = 0, acc_a = 0;
    logic [21:0] pa_a = '0, pa_b = '0;
    logic        plow_a = 1'b0, plow_b = 1'b0;
    int          ack_dly_a = 0, hold_cnt_a = 0;
    logic        pend_a = 1'b0;
    logic [35:0] prev_a = '0;
    logic        c_act = 1'b0;

    flash_rom_loader #(.SRC_BASE(SRC_A), .DST_BASE(DST_A), .LEN(4), .FLASH_WAIT(FW_A), .AUTOSTART(1'b1)) u_a (
        .zclk(zclk), .rst(rst), .start(start_a), .flash_a(fa_a), .flash_ce_n(ce_a), .flash_oe_n(oe_a),
        .flash_d(fd_a), .w_req(wreq_a), .w_addr(waddr_a), .w_data(wdata_a), .w_be(wbe_a), .w_ack(wack_a),
        .cpu_hold(hold_a), .busy(busy_a), .done(done_a), .checksum(cks_a));

    flash_rom_loader #(.SRC_BASE(SRC_B), .DST_BASE(DST_B), .LEN(3), .FLASH_WAIT(FW_B), .AUTOSTART(1'b0)) u_b (
        .zclk(zclk), .rst(rst), .start(start_b), .flash_a(fa_b), .flash_ce_n(ce_b), .flash_oe_n(oe_b),
        .flash_d(fd_b), .w_req(wreq_b), .w_addr(waddr_b), .w_data(wdata_b), .w_be(wbe_b), .w_ack(wack_b),
        .cpu_hold(hold_b), .busy(busy_b), .done(done_b), .checksum(cks_b));

    flash_rom_loader #(.SRC_BASE(22'h0), .DST_BASE(18'h0), .LEN(0), .FLASH_WAIT(3), .AUTOSTART(1'b1)) u_c (
        .zclk(zclk), .rst(rst), .start(start_c), .flash_a(fa_c), .flash_ce_n(ce_c), .flash_oe_n(oe_c),
        .flash_d(fd_c), .w_req(wreq_c), .w_addr(waddr_c), .w_data(wdata_c), .w_be(wbe_c), .w_ack(wack_c),
        .cpu_hold(hold_c), .busy(busy_c), .done(done_c), .checksum(cks_c));

    // 100 MHz clock
    always #5 zclk = ~zclk;

    function automatic logic [7:0] fbyte(input logic [21:0] a, input logic [21:0] base);
        logic [21:0] off;
        off = a - base;
        case (off)
            22'd0:   return 8'h11;
            22'd1:   return 8'h22;
            22'd2:   return 8'h33;
            22'd3:   return 8'h44;
            default: return 8'h5A;
        endcase
    endfunction

    // Flash data is garbage until the enables have been low for the full access time
    assign fd_a = (cnt_a >= FW_A + 2) ? fbyte(fa_a, SRC_A) : 8'hA5;
    assign fd_b = (cnt_b >= FW_B + 2) ? fbyte(fa_b, SRC_B) : 8'hA5;

    task automatic chk(input string nm, input logic [95:0] got, input logic [95:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic pop_chk(input string nm, inout logic [35:0] q[$], input logic [35:0] got);
        if (q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s: unexpected write %0h with nothing expected", nm, got);
        end else begin
            chk(nm, got, q.pop_front());
        end
    endtask

    // Flash models, arbiter models and write scoreboard, all evaluated mid-cycle
    always @(negedge zclk) begin
        if (!ce_a && !oe_a) begin
            if (plow_a && fa_a == pa_a) cnt_a++;
            else begin cnt_a = 1; acc_a++; end
            plow_a = 1'b1; pa_a = fa_a;
        end else begin
            cnt_a = 0; plow_a = 1'b0;
        end
        if (!ce_b && !oe_b) begin
            if (plow_b && fa_b == pa_b) cnt_b++;
            else cnt_b = 1;
            plow_b = 1'b1; pa_b = fa_b;
        end else begin
            cnt_b = 0; plow_b = 1'b0;
        end

        if (wreq_a) begin
            if (pend_a) chk("a_req_stable", {waddr_a, wdata_a, wbe_a}, prev_a);
            chk("a_flash_idle_during_req", {ce_a, oe_a}, 2'b11);
            wack_a     = (hold_cnt_a == ack_dly_a);
            hold_cnt_a = wack_a ? 0 : hold_cnt_a + 1;
            pend_a     = !wack_a;
            prev_a     = {waddr_a, wdata_a, wbe_a};
            if (wack_a) pop_chk("a_write", qa, {waddr_a, wdata_a, wbe_a});
        end else begin
            wack_a = 1'b0; hold_cnt_a = 0; pend_a = 1'b0;
        end

        wack_b = wreq_b;
        if (wreq_b) begin
            chk("b_flash_idle_during_req", {ce_b, oe_b}, 2'b11);
            pop_chk("b_write", qb, {waddr_b, wdata_b, wbe_b});
        end

        if (!ce_c || !oe_c || wreq_c) c_act = 1'b1;
    end

    task automatic tick();
        @(negedge zclk);
        #1;
    endtask

    task automatic wait_done(input bit sel_b, input int max, output int n);
        n = 0;
        while (((sel_b ? done_b : done_a) == 1'b0) && n < max) begin
            tick();
            n++;
        end
        if ((sel_b ? done_b : done_a) == 1'b0) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s: done not seen within %0d cycles", sel_b ? "b_done" : "a_done", max);
        end
    endtask

    // Directed scenarios
    initial begin
        int n;
        int base;
        logic [79:0] rst_vec;
        rst_vec = {22'h0, 1'b1, 1'b1, 1'b0, 18'h0, 16'h0, 2'b00, 1'b1, 1'b0, 1'b0, 16'h0};

        rst = 1'b1;
        repeat (3) tick();
        chk("a_reset", {fa_a, ce_a, oe_a, wreq_a, waddr_a, wdata_a, wbe_a, hold_a, busy_a, done_a, cks_a}, rst_vec);
        chk("b_reset", {fa_b, ce_b, oe_b, wreq_b, waddr_b, wdata_b, wbe_b, hold_b, busy_b, done_b, cks_b}, rst_vec);
        chk("c_reset", {fa_c, ce_c, oe_c, wreq_c, waddr_c, wdata_c, wbe_c, hold_c, busy_c, done_c, cks_c}, rst_vec);

        // Normal copy, immediate ack
        qa.push_back({DST_A, 16'h2211, 2'b11});
        qa.push_back({DST_A + 18'd1, 16'h4433, 2'b11});
        rst = 1'b0;
        tick();
        chk("a_autostart_faddr", {fa_a, ce_a, oe_a, busy_a, hold_a}, {SRC_A, 1'b0, 1'b0, 1'b1, 1'b1});
        chk("c_len0_done", {done_c, busy_c, hold_c, cks_c}, {1'b1, 1'b0, 1'b0, 16'h0000});
        chk("b_idle_waits_start", {busy_b, done_b, hold_b}, 3'b001);
        wait_done(1'b0, 200, n);
        chk("a_cycles", n, 22);
        chk("a_final", {done_a, busy_a, hold_a, cks_a}, {1'b1, 1'b0, 1'b0, 16'h00AA});
        chk("a_queue_drained", qa.size(), 0);

        // Odd length with both address spaces wrapping
        qb.push_back({DST_B, 16'h2211, 2'b11});
        qb.push_back({18'h00000, 16'h0033, 2'b01});
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        chk("b_start_faddr", {fa_b, ce_b, busy_b, hold_b, done_b}, {22'h3FFFFE, 1'b0, 1'b1, 1'b1, 1'b0});
        wait_done(1'b1, 200, n);
        chk("b_cycles", n, 8);
        chk("b_final", {done_b, busy_b, hold_b, cks_b}, {1'b1, 1'b0, 1'b0, 16'h0066});
        chk("b_queue_drained", qb.size(), 0);

        // Slow arbiter plus a start pulse while busy
        ack_dly_a = 5;
        qa.push_back({DST_A, 16'h2211, 2'b11});
        qa.push_back({DST_A + 18'd1, 16'h4433, 2'b11});
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        chk("a_restart_clears", {done_a, busy_a, hold_a, cks_a}, {1'b0, 1'b1, 1'b1, 16'h0000});
        n = 0;
        while (qa.size() != 1 && n < 200) begin tick(); n++; end
        chk("a_first_slow_write_seen", qa.size(), 1);
        chk("a_busy_before_start", busy_a, 1'b1);
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        wait_done(1'b0, 300, n);
        chk("a_slow_final", {done_a, hold_a, cks_a}, {1'b1, 1'b0, 16'h00AA});
        chk("a_slow_queue_drained", qa.size(), 0);
        repeat (4) tick();
        chk("a_checksum_frozen", {done_a, cks_a}, {1'b1, 16'h00AA});

        // Reset during the second byte's wait states
        ack_dly_a = 0;
        base = acc_a;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        n = 0;
        while (!(acc_a == base + 2 && cnt_a == 2) && n < 200) begin tick(); n++; end
        chk("a_reached_second_fwait", {acc_a == base + 2, cnt_a == 2}, 2'b11);
        rst = 1'b1;
        tick();
        chk("a_rst_mid_copy", {wreq_a, ce_a, oe_a, busy_a, hold_a, done_a}, 6'b011010);
        qa.push_back({DST_A, 16'h2211, 2'b11});
        qa.push_back({DST_A + 18'd1, 16'h4433, 2'b11});
        rst = 1'b0;
        tick();
        chk("a_restart_from_src", {fa_a, ce_a, busy_a}, {SRC_A, 1'b0, 1'b1});
        wait_done(1'b0, 200, n);
        chk("a_after_rst_final", {done_a, hold_a, cks_a}, {1'b1, 1'b0, 16'h00AA});
        chk("a_after_rst_drained", qa.size(), 0);

        chk("c_no_bus_activity", c_act, 1'b0);
        chk("c_still_done", {done_c, cks_c}, {1'b1, 16'h0000});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
